// File: rtl/cbfp_pkg.sv
// cbfp_pkg: shared magnitude type and leading-sign-bit helpers for the CBFP detector
package cbfp_pkg;
  localparam int MAG_WIDTH = 5;
  typedef logic [MAG_WIDTH-1:0] mag_t;
  function automatic mag_t lsb_count(input logic [63:0] x, input int dw);
    mag_t n = '0;
    logic run = 1'b1;
    for (int i = 62; i >= 0; i--)
      if (i <= dw - 2 && run) begin
        if (x[6'(i)] == x[6'(dw - 1)]) n = n + 1'b1;
        else run = 1'b0;
      end
    return n;
  endfunction
  function automatic mag_t min_mag(input mag_t a, input mag_t b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/cbfp_min_tree.sv
// cbfp_min_tree: combinational minimum across all lane counts of one beat
module cbfp_min_tree
  import cbfp_pkg::*;
#(
  parameter int LANES = 16,
  parameter int MAG_WIDTH = 5
) (
  input  logic [MAG_WIDTH-1:0] din [0:LANES-1],
  output logic [MAG_WIDTH-1:0] dout
);
  // fold the lanes into a single running minimum
  always_comb begin
    dout = din[0];
    for (int i = 1; i < LANES; i++) dout = (din[i] < dout) ? din[i] : dout;
  end
endmodule

// File: rtl/cbfp_block_exp_detect.sv
// cbfp_block_exp_detect: per-lane sign-bit count, beat minimum and per-block exponent/shift
module cbfp_block_exp_detect
  import cbfp_pkg::*;
#(
  parameter int DATA_WIDTH = 23,
  parameter int LANES = 16,
  parameter int BLOCK_BEATS = 4,
  parameter int MAG_WIDTH = cbfp_pkg::MAG_WIDTH,
  parameter int MAX_SHIFT = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  din_valid,
  input  logic                  din_sop,
  input  logic [DATA_WIDTH-1:0] din [0:LANES-1],
  output logic                  mag_valid,
  output logic [MAG_WIDTH-1:0]  mag_out [0:LANES-1],
  output logic                  blk_valid,
  output logic [MAG_WIDTH-1:0]  blk_exp,
  output logic [MAG_WIDTH-1:0]  blk_shift,
  output logic                  blk_abort
);
  localparam int CW = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  logic                 s1_sop, s2_valid, s2_sop, first, last;
  logic [MAG_WIDTH-1:0] tree_min, lane_min, acc, acc_nxt;
  logic [CW-1:0]        cnt, idx;

  cbfp_min_tree #(.LANES(LANES), .MAG_WIDTH(MAG_WIDTH)) u_min (.din(mag_out), .dout(tree_min));

  // S1: register each lane's leading-sign count
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mag_valid <= 1'b0;
      s1_sop <= 1'b0;
      for (int i = 0; i < LANES; i++) mag_out[i] <= '0;
    end else begin
      mag_valid <= din_valid;
      s1_sop <= din_valid & din_sop;
      if (din_valid)
        for (int i = 0; i < LANES; i++) mag_out[i] <= MAG_WIDTH'(lsb_count(64'(din[i]), DATA_WIDTH));
    end

  // S2: register the minimum across lanes
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_sop <= 1'b0;
      lane_min <= '0;
    end else begin
      s2_valid <= mag_valid;
      s2_sop <= s1_sop;
      if (mag_valid) lane_min <= tree_min;
    end

  // a sop restarts the block regardless of how many beats were already counted
  always_comb begin
    first = (cnt == '0) || s2_sop;
    idx = first ? '0 : cnt;
    last = idx == CW'(BLOCK_BEATS - 1);
    acc_nxt = first ? lane_min : ((lane_min < acc) ? lane_min : acc);
  end

  // S3: beat counter, running block minimum and result registers
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      acc <= '0;
      blk_valid <= 1'b0;
      blk_abort <= 1'b0;
      blk_exp <= '0;
      blk_shift <= '0;
    end else begin
      blk_valid <= s2_valid && last;
      blk_abort <= s2_valid && s2_sop && (cnt != '0);
      if (s2_valid) begin
        acc <= acc_nxt;
        cnt <= last ? '0 : idx + 1'b1;
        if (last) begin
          blk_exp <= acc_nxt;
          blk_shift <= (acc_nxt > MAG_WIDTH'(MAX_SHIFT)) ? MAG_WIDTH'(MAX_SHIFT) : acc_nxt;
        end
      end
    end
endmodule

// File: tb/tb_cbfp_block_exp_detect.sv
// tb_cbfp_block_exp_detect: scoreboard bench for default and narrow/single-beat configurations
module tb_cbfp_block_exp_detect;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic v0 = 1'b0, sop0 = 1'b0, mv0, bv0, ba0;
  logic [22:0] d0 [0:15];
  logic [4:0] mo0 [0:15];
  logic [4:0] be0, bs0;
  logic v1 = 1'b0, sop1 = 1'b0, mv1, bv1, ba1;
  logic [15:0] d1 [0:7];
  logic [4:0] mo1 [0:7];
  logic [4:0] be1, bs1;

  cbfp_block_exp_detect u0 (
    .clk(clk), .rstn(rstn), .din_valid(v0), .din_sop(sop0), .din(d0),
    .mag_valid(mv0), .mag_out(mo0), .blk_valid(bv0), .blk_exp(be0),
    .blk_shift(bs0), .blk_abort(ba0));

  cbfp_block_exp_detect #(.DATA_WIDTH(16), .LANES(8), .BLOCK_BEATS(1)) u1 (
    .clk(clk), .rstn(rstn), .din_valid(v1), .din_sop(sop1), .din(d1),
    .mag_valid(mv1), .mag_out(mo1), .blk_valid(bv1), .blk_exp(be1),
    .blk_shift(bs1), .blk_abort(ba1));

  typedef struct {int due; int m[16];} mag_e_t;
  typedef struct {int due; int e; int s;} blk_e_t;
  typedef struct {logic [22:0] x; int exp;} lane_vec_t;

  mag_e_t qm[2][$];
  blk_e_t qb[2][$];
  int     qa[2][$];
  int     mcnt[2], macc[2];
  int     cyc = 0, n_vec = 0, n_bad = 0;
  logic [22:0] z [16];
  logic [22:0] s [16];
  lane_vec_t tbl [6];

  function automatic int ref_cnt(logic [31:0] x, int dw);
    logic [31:0] y;
    int len = 0;
    y = (((x >> (dw - 1)) & 32'd1) != 0) ? ~x : x;
    y = y & ((32'd1 << (dw - 1)) - 32'd1);
    while (y != 0) begin
      y = y >> 1;
      len++;
    end
    return dw - 1 - len;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int k, bit sop, int m[16], int lanes, int bb);
    mag_e_t e;
    blk_e_t b;
    int lm, idx;
    bit first;
    e.due = cyc + 1;
    e.m = m;
    qm[k].push_back(e);
    lm = m[0];
    for (int i = 1; i < lanes; i++) if (m[i] < lm) lm = m[i];
    if (sop && mcnt[k] != 0) qa[k].push_back(cyc + 3);
    first = sop || mcnt[k] == 0;
    macc[k] = first ? lm : (lm < macc[k] ? lm : macc[k]);
    idx = first ? 0 : mcnt[k];
    if (idx == bb - 1) begin
      b.due = cyc + 3;
      b.e = macc[k];
      b.s = macc[k] > 12 ? 12 : macc[k];
      qb[k].push_back(b);
      mcnt[k] = 0;
    end else mcnt[k] = idx + 1;
  endtask

  task automatic check(int k, bit mv, int mo[16], int lanes, bit bv, int be, int bs, bit ba);
    mag_e_t e;
    blk_e_t b;
    int bad;
    if (qm[k].size() > 0 && qm[k][0].due == cyc) begin
      e = qm[k].pop_front();
      chk($sformatf("d%0d mag_valid", k), mv, 1);
      bad = 0;
      for (int i = lanes - 1; i >= 0; i--) if (mo[i] != e.m[i]) bad = i;
      chk($sformatf("d%0d mag_out lane %0d", k, bad), mo[bad], e.m[bad]);
    end else if (mv) chk($sformatf("d%0d spurious mag_valid", k), 1, 0);
    if (qb[k].size() > 0 && qb[k][0].due == cyc) begin
      b = qb[k].pop_front();
      chk($sformatf("d%0d blk_valid", k), bv, 1);
      chk($sformatf("d%0d blk_exp", k), be, b.e);
      chk($sformatf("d%0d blk_shift", k), bs, b.s);
    end else if (bv) chk($sformatf("d%0d spurious blk_valid", k), 1, 0);
    if (qa[k].size() > 0 && qa[k][0] == cyc) begin
      void'(qa[k].pop_front());
      chk($sformatf("d%0d blk_abort", k), ba, 1);
    end else if (ba) chk($sformatf("d%0d spurious blk_abort", k), 1, 0);
  endtask

  task automatic tick();
    int m0[16], m1[16];
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 16; i++) m0[i] = mo0[i];
    for (int i = 0; i < 16; i++) m1[i] = (i < 8) ? int'(mo1[i]) : 0;
    check(0, mv0, m0, 16, bv0, be0, bs0, ba0);
    check(1, mv1, m1, 8, bv1, be1, bs1, ba1);
  endtask

  task automatic beat0(bit sop, logic [22:0] x[16], int ovr = -1);
    int m[16];
    for (int i = 0; i < 16; i++) m[i] = ref_cnt(32'(x[i]), 23);
    if (ovr >= 0) m[0] = ovr;
    push(0, sop, m, 16, 4);
    v0 = 1'b1;
    sop0 = sop;
    d0 = x;
    tick();
    v0 = 1'b0;
    sop0 = 1'b0;
  endtask

  task automatic beat1(bit sop, logic [15:0] x[8]);
    int m[16];
    for (int i = 0; i < 16; i++) m[i] = (i < 8) ? ref_cnt(32'(x[i]), 16) : 0;
    push(1, sop, m, 8, 1);
    v1 = 1'b1;
    sop1 = sop;
    d1 = x;
    tick();
    v1 = 1'b0;
    sop1 = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      z[i] = '0;
      d0[i] = '0;
    end
    for (int i = 0; i < 8; i++) d1[i] = '0;
    mcnt = '{0, 0};
    macc = '{0, 0};
    tbl = '{'{23'h000001, 21}, '{23'h7FFFFF, 22}, '{23'h400000, 0},
            '{23'h200000, 0}, '{23'h100000, 1}, '{23'h000000, 22}};

    idle(2);
    chk("reset mag_valid", mv0, 0);
    chk("reset blk_exp", be0, 0);
    chk("reset blk_valid", bv0, 0);
    rstn = 1'b1;
    idle(2);

    foreach (tbl[j]) begin
      s = z;
      s[0] = tbl[j].x;
      beat0(1'b0, s, tbl[j].exp);
    end
    idle(4);

    for (int b = 0; b < 4; b++) begin
      s = z;
      if (b == 2) s[7] = 23'h000400;
      beat0(b == 0, s);
    end
    idle(4);
    chk("block min blk_exp", be0, 11);
    chk("block min blk_shift", bs0, 11);

    for (int b = 0; b < 4; b++) begin
      s = z;
      if (b == 1) s[3] = 23'h000002;
      beat0(b == 0, s);
      idle(b + 1);
    end
    idle(4);
    chk("clamp blk_exp", be0, 20);
    chk("clamp blk_shift", bs0, 12);

    for (int b = 0; b < 6; b++) begin
      s = z;
      if (b == 0) s[1] = 23'h400000;
      if (b == 3) s[5] = 23'h001000;
      beat0(b == 0 || b == 2, s);
    end
    idle(5);
    chk("abort restart blk_exp", be0, 9);

    s = z;
    s[2] = 23'h000010;
    beat0(1'b1, s);
    beat0(1'b0, s);
    #3;
    rstn = 1'b0;
    #1;
    chk("async reset mag_valid", mv0, 0);
    chk("async reset mag_out lane 2", mo0[2], 0);
    chk("async reset blk_exp", be0, 0);
    chk("async reset blk_shift", bs0, 0);
    chk("async reset blk_valid", bv0, 0);
    for (int k = 0; k < 2; k++) begin
      qm[k].delete();
      qb[k].delete();
      qa[k].delete();
      mcnt[k] = 0;
      macc[k] = 0;
    end
    tick();
    rstn = 1'b1;
    idle(6);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        int sh;
        sh = $urandom_range(0, 22);
        for (int i = 0; i < 16; i++) begin
          s[i] = 23'($urandom) >> sh;
          if ($urandom_range(0, 1) != 0) s[i] = ~s[i];
        end
        beat0($urandom_range(0, 7) == 0, s);
      end else tick();
    end
    idle(5);

    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [15:0] x[8];
        int sh;
        sh = $urandom_range(0, 16);
        for (int i = 0; i < 8; i++) begin
          x[i] = 16'($urandom) >> sh;
          if ($urandom_range(0, 1) != 0) x[i] = ~x[i];
        end
        beat1($urandom_range(0, 3) == 0, x);
      end else tick();
    end
    idle(5);

    chk("d0 pending expectations", qm[0].size() + qb[0].size() + qa[0].size(), 0);
    chk("d1 pending expectations", qm[1].size() + qb[1].size() + qa[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
